// File: rtl/rom_uart_loader.sv
// UART-fed ROM image loader: 8N1 receiver plus frame parser that streams data bytes
// to the ROM write port and holds the CPU in reset until a frame checks out.
module rom_uart_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_CLKS = 12000,
    parameter int BOOT_HOLD    = 1
) (
    input  logic        clk_12m,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [15:0] rom_write_addr,
    output logic [7:0]  rom_write_data,
    output logic        rom_write_en,
    output logic        cpu_rst,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR_H = 3'd1;
    localparam logic [2:0] ST_ADDR_L = 3'd2;
    localparam logic [2:0] ST_LEN_H  = 3'd3;
    localparam logic [2:0] ST_LEN_L  = 3'd4;
    localparam logic [2:0] ST_DATA   = 3'd5;
    localparam logic [2:0] ST_CSUM   = 3'd6;

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_byte;
    logic             rx_byte_valid;
    logic             rx_frame_err;

    logic [2:0]       state;
    logic [15:0]      addr;
    logic [15:0]      count;
    logic [7:0]       sum;
    logic [7:0]       sum_next;
    logic [TMO_W-1:0] timer;

    // Receiver: start edge is re-checked at half a bit, then every bit sampled mid-bit.
    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            rx_prev       <= 1'b1;
            rx_state      <= RX_IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            rx_shift      <= '0;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_meta       <= uart_rx;
            rx_sync       <= rx_meta;
            rx_prev       <= rx_sync;
            rx_byte_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    if (rx_prev && !rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_byte       <= rx_shift;
                            rx_byte_valid <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        sum_next = sum + rx_byte;
    end

    // Parser: byte events take priority over framing errors and the idle timeout.
    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            addr           <= '0;
            count          <= '0;
            sum            <= '0;
            timer          <= '0;
            rom_write_addr <= '0;
            rom_write_data <= '0;
            rom_write_en   <= 1'b0;
            cpu_rst        <= (BOOT_HOLD != 0);
            load_busy      <= 1'b0;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
        end else begin
            rom_write_en <= 1'b0;
            load_done    <= 1'b0;
            load_busy    <= (state != ST_IDLE);
            if (rx_byte_valid) begin
                timer <= '0;
                case (state)
                    ST_IDLE: begin
                        if (rx_byte == 8'hA5) begin
                            load_err <= 1'b0;
                            cpu_rst  <= 1'b1;
                            sum      <= '0;
                            state    <= ST_ADDR_H;
                        end
                    end
                    ST_ADDR_H: begin
                        addr[15:8] <= rx_byte;
                        sum        <= sum_next;
                        state      <= ST_ADDR_L;
                    end
                    ST_ADDR_L: begin
                        addr[7:0] <= rx_byte;
                        sum       <= sum_next;
                        state     <= ST_LEN_H;
                    end
                    ST_LEN_H: begin
                        count[15:8] <= rx_byte;
                        sum         <= sum_next;
                        state       <= ST_LEN_L;
                    end
                    ST_LEN_L: begin
                        count[7:0] <= rx_byte;
                        sum        <= sum_next;
                        state      <= ({count[15:8], rx_byte} == 16'h0000) ? ST_CSUM : ST_DATA;
                    end
                    ST_DATA: begin
                        rom_write_en   <= 1'b1;
                        rom_write_addr <= addr;
                        rom_write_data <= rx_byte;
                        addr           <= addr + 16'd1;
                        count          <= count - 16'd1;
                        sum            <= sum_next;
                        if (count == 16'd1) state <= ST_CSUM;
                    end
                    ST_CSUM: begin
                        if (sum_next == 8'h00) begin
                            load_done <= 1'b1;
                            cpu_rst   <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (rx_frame_err) begin
                load_err <= 1'b1;
                timer    <= '0;
                state    <= ST_IDLE;
            end else if (state != ST_IDLE) begin
                if (timer == TMO_LAST) begin
                    load_err <= 1'b1;
                    timer    <= '0;
                    state    <= ST_IDLE;
                end else begin
                    timer <= timer + 1'b1;
                end
            end else begin
                timer <= '0;
            end
        end
    end

endmodule
